blackjack_hand_tracker: RTL and testbench
=========================================

Name: blackjack_hand_tracker

Overview:
- Sits directly downstream of the deck data path, which returns a registered 8-bit card code one cycle after a request strobe.
- Requests one card per hit and accumulates the blackjack hand score, tracking soft aces.
- Reports bust, blackjack, card count and error status to the game-control FSM.

Parameters:
- MAX_CARDS, 11: maximum cards per hand; further hits are ignored.
- WAIT_TIMEOUT, 15: cycles spent in WAIT without card_valid_i before the error abort.
- DEALER_STAND, 17: stand threshold, used only by the optional auto-play feature.

Ports:
- clk_dp_i  in  1  clock.
- rst_dp_i  in  1  asynchronous, active-low reset.
- new_hand_i  in  1  clear the hand; highest priority.
- hit_i  in  1  request one card (single-cycle pulse).
- card_i  in  8  card code from the deck path; [3:0] rank 1..13; 0 or >13 is invalid.
- card_valid_i  in  1  card_i is valid this cycle.
- req_card_o  out  1  one-cycle request strobe to the deck path.
- score_o  out  5  best hand total (0..30).
- soft_o  out  1  total currently counts an ace as 11.
- card_count_o  out  4  cards in the hand.
- bust_o  out  1  score_o > 21.
- blackjack_o  out  1  score 21 with exactly 2 cards.
- busy_o  out  1  FSM not in IDLE.
- err_o  out  1  sticky error: invalid card or timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, internal soft-ace count 0, timer 0.
- States and transitions:
  - IDLE: hit_i accepted only if !bust_o, card_count_o<MAX_CARDS and score_o<21; otherwise ignored. On accept, go to REQ.
  - REQ: req_card_o=1 for exactly this cycle; go to WAIT with timer cleared.
  - WAIT: on card_valid_i, register card_i and go to ADD. Otherwise increment the timer. When the timer reaches WAIT_TIMEOUT, set err_o and return to IDLE; the hand is unchanged.
  - ADD:
    - Card points: rank 1 = 11 (soft count +1), ranks 2..10 = face value, ranks 11..13 = 10.
    - sum = score + points, computed 6 bits wide.
    - If sum>21 and soft count>0: subtract 10 and decrement the soft count. At most one reduction is ever needed.
    - Update score_o, card_count_o+1, soft_o=(soft count>0), bust_o=(score>21), blackjack_o=(score==21 && count==2).
    - Return to IDLE.
    - Invalid rank: no hand update, set err_o, go to IDLE.
- Nominal latency: hit_i to updated score_o is 4 cycles when the card arrives the cycle after the request (REQ, WAIT, ADD, IDLE).
- new_hand_i, any state: next cycle all hand outputs and err_o are 0 and state is IDLE. Any in-flight card is discarded. If hit_i arrives the same cycle, hit_i is ignored.
- card_valid_i outside WAIT is ignored.
- hit_i while busy_o is ignored; hits are not queued.

Optional Feature:
- Macro: BLACKJACK_DEALER_AUTO_EN.
- Defined: after every ADD that leaves score<DEALER_STAND, !bust and count<MAX_CARDS, the FSM goes straight to REQ without hit_i, giving dealer auto-play. The dealer stands on soft 17. Adds 1-bit output stand_o, set when the FSM settles with score>=DEALER_STAND and no bust; cleared by new_hand_i.
- Undefined: draws happen only on hit_i; stand_o is absent.

Decomposition:
- Shared include blackjack_defs.vh: rank constants (ACE=1, KING=13), BLACKJACK=21, state encodings (IDLE, REQ, WAIT, ADD), and the card-code field positions shared with the deck path.
- One natural sub-module: blackjack_card_points. It is combinational: rank to 4-bit points, is_ace flag and invalid flag.

Test Plan:
- Reset, then hit with cards rank 1 and rank 13 -> score_o=21, soft_o=1, blackjack_o=1, card_count_o=2.
- Cards 1, 1, 9 -> after the 2nd card score=12 soft=1; after the 3rd score=21 soft=1, blackjack_o=0.
- Cards 10, 6, 12 -> score=26, bust_o=1; a further hit_i produces no req_card_o.
- Hit with card_valid_i withheld for 15 cycles -> err_o=1, busy_o=0, score unchanged. Then new_hand_i -> err_o=0.
- Card code 0x00 returned -> err_o=1, card_count_o unchanged. Assert new_hand_i during WAIT, then card_valid_i arrives -> card is ignored and all outputs are 0.
- With BLACKJACK_DEALER_AUTO_EN, card sequence 1, 6 -> stops after 2 requests with score=17, soft_o=1, stand_o=1.

Source files
------------

// File: rtl/blackjack_hand_tracker_pkg.sv
// Shared constants and state encoding for the blackjack hand tracker and the deck path.
package blackjack_hand_tracker_pkg;

    localparam int MAX_CARDS_DEF    = 11;
    localparam int WAIT_TIMEOUT_DEF = 15;
    localparam int DEALER_STAND_DEF = 17;

    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_TEN  = 4'd10;
    localparam logic [3:0] RANK_KING = 4'd13;
    localparam logic [4:0] BLACKJACK = 5'd21;

    // Card code layout agreed with the deck path: rank in the low nibble, suit above it.
    localparam int CARD_RANK_LSB = 0;
    localparam int CARD_RANK_MSB = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ADD  = 2'd3
    } state_t;

endpackage

// File: rtl/blackjack_card_points.sv
// Combinational rank decoder: blackjack points, ace flag and invalid-rank flag.
module blackjack_card_points
    import blackjack_hand_tracker_pkg::*;
(
    input  logic [3:0] i_rank,
    output logic [3:0] o_points,
    output logic       o_isAce,
    output logic       o_invalid
);

    always_comb begin
        o_points  = 4'd0;
        o_isAce   = 1'b0;
        o_invalid = 1'b0;
        if (i_rank == 4'd0 || i_rank > RANK_KING) begin
            o_invalid = 1'b1;
        end else if (i_rank == RANK_ACE) begin
            o_points = 4'd11;
            o_isAce  = 1'b1;
        end else if (i_rank > RANK_TEN) begin
            o_points = RANK_TEN;
        end else begin
            o_points = i_rank;
        end
    end

endmodule

// File: rtl/blackjack_hand_tracker.sv
// Blackjack hand tracker: requests one card per hit from the deck path and keeps the hand score.
// Defining BLACKJACK_DEALER_AUTO_EN enables dealer auto-play and adds the stand_o output.
module blackjack_hand_tracker
    import blackjack_hand_tracker_pkg::*;
#(
    parameter int MAX_CARDS    = MAX_CARDS_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
`ifdef BLACKJACK_DEALER_AUTO_EN
    ,
    parameter int DEALER_STAND = DEALER_STAND_DEF
`endif
) (
    input  logic       clk_dp_i,
    input  logic       rst_dp_i,
    input  logic       new_hand_i,
    input  logic       hit_i,
    input  logic [7:0] card_i,
    input  logic       card_valid_i,
    output logic       req_card_o,
    output logic [4:0] score_o,
    output logic       soft_o,
    output logic [3:0] card_count_o,
    output logic       bust_o,
    output logic       blackjack_o,
    output logic       busy_o,
`ifdef BLACKJACK_DEALER_AUTO_EN
    output logic       stand_o,
`endif
    output logic       err_o
);

    localparam logic [3:0] LP_MAX_CARDS  = 4'(MAX_CARDS);
    localparam logic [3:0] LP_TIMER_LAST = 4'(WAIT_TIMEOUT - 1);
`ifdef BLACKJACK_DEALER_AUTO_EN
    localparam logic [5:0] LP_STAND      = 6'(DEALER_STAND);
    logic                  r_stand;
`endif

    state_t     r_state, w_next;
    logic [4:0] r_score;
    logic [3:0] r_softCount, r_count, r_timer, r_rank;
    logic       r_err;
    logic [3:0] w_points, w_softSum, w_adjSoft;
    logic [5:0] w_sum, w_adjSum;
    logic       w_isAce, w_invalid, w_bust, w_hitOk, w_autoDraw, w_unusedSuit;

    assign w_unusedSuit = ^card_i[7:4];

    blackjack_card_points u_points (
        .i_rank    (r_rank),
        .o_points  (w_points),
        .o_isAce   (w_isAce),
        .o_invalid (w_invalid)
    );

    // Adding a card can push a soft hand over 21; demoting one ace (11 -> 1) always suffices.
    always_comb begin
        w_sum     = {1'b0, r_score} + {2'b00, w_points};
        w_softSum = r_softCount + {3'b000, w_isAce};
        w_adjSum  = w_sum;
        w_adjSoft = w_softSum;
        if (w_sum > {1'b0, BLACKJACK} && w_softSum != 4'd0) begin
            w_adjSum  = w_sum - 6'd10;
            w_adjSoft = w_softSum - 4'd1;
        end
    end

    assign w_bust  = (r_score > BLACKJACK);
    assign w_hitOk = hit_i && !w_bust && (r_count < LP_MAX_CARDS) && (r_score < BLACKJACK);

`ifdef BLACKJACK_DEALER_AUTO_EN
    assign w_autoDraw = !w_invalid && (w_adjSum < LP_STAND) && ((r_count + 4'd1) < LP_MAX_CARDS);
`else
    assign w_autoDraw = 1'b0;
`endif

    always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
        if (!rst_dp_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hitOk) w_next = REQ;
            REQ:     w_next = WAIT;
            WAIT:    if (card_valid_i) w_next = ADD;
                     else if (r_timer == LP_TIMER_LAST) w_next = IDLE;
            ADD:     w_next = w_autoDraw ? REQ : IDLE;
            default: w_next = IDLE;
        endcase
        if (new_hand_i) w_next = IDLE;
    end

    // Hand registers; new_hand_i wipes everything, including a card still in flight.
    always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
        if (!rst_dp_i) begin
            r_score     <= 5'd0;
            r_softCount <= 4'd0;
            r_count     <= 4'd0;
            r_timer     <= 4'd0;
            r_rank      <= 4'd0;
            r_err       <= 1'b0;
`ifdef BLACKJACK_DEALER_AUTO_EN
            r_stand     <= 1'b0;
`endif
        end else if (new_hand_i) begin
            r_score     <= 5'd0;
            r_softCount <= 4'd0;
            r_count     <= 4'd0;
            r_timer     <= 4'd0;
            r_rank      <= 4'd0;
            r_err       <= 1'b0;
`ifdef BLACKJACK_DEALER_AUTO_EN
            r_stand     <= 1'b0;
`endif
        end else begin
            case (r_state)
                REQ: r_timer <= 4'd0;
                WAIT: begin
                    if (card_valid_i) begin
                        r_rank <= card_i[CARD_RANK_MSB:CARD_RANK_LSB];
                    end else if (r_timer == LP_TIMER_LAST) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
                ADD: begin
                    if (w_invalid) begin
                        r_err <= 1'b1;
                    end else begin
                        r_score     <= w_adjSum[4:0];
                        r_softCount <= w_adjSoft;
                        r_count     <= r_count + 4'd1;
`ifdef BLACKJACK_DEALER_AUTO_EN
                        if (w_adjSum >= LP_STAND && w_adjSum <= {1'b0, BLACKJACK}) r_stand <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_card_o   = (r_state == REQ);
        busy_o       = (r_state != IDLE);
        score_o      = r_score;
        soft_o       = (r_softCount != 4'd0);
        card_count_o = r_count;
        bust_o       = w_bust;
        blackjack_o  = (r_score == BLACKJACK) && (r_count == 4'd2);
        err_o        = r_err;
`ifdef BLACKJACK_DEALER_AUTO_EN
        stand_o      = r_stand;
`endif
    end

endmodule

// File: tb/tb_blackjack_hand_tracker.sv
// Directed bench for blackjack_hand_tracker; the dealer auto-play scenario runs when
// BLACKJACK_DEALER_AUTO_EN is defined, the manual-hit scenarios otherwise.
module tb_blackjack_hand_tracker;

    logic       clk_dp_i = 1'b0;
    logic       rst_dp_i = 1'b0;
    logic       new_hand_i = 1'b0;
    logic       hit_i = 1'b0;
    logic [7:0] card_i = 8'h00;
    logic       card_valid_i = 1'b0;
    logic       req_card_o, soft_o, bust_o, blackjack_o, busy_o, err_o;
    logic [4:0] score_o;
    logic [3:0] card_count_o;
`ifdef BLACKJACK_DEALER_AUTO_EN
    logic       stand_o;
`endif

    int checks = 0;
    int errors = 0;
    int reqCount = 0;

    blackjack_hand_tracker dut (
        .clk_dp_i     (clk_dp_i),
        .rst_dp_i     (rst_dp_i),
        .new_hand_i   (new_hand_i),
        .hit_i        (hit_i),
        .card_i       (card_i),
        .card_valid_i (card_valid_i),
        .req_card_o   (req_card_o),
        .score_o      (score_o),
        .soft_o       (soft_o),
        .card_count_o (card_count_o),
        .bust_o       (bust_o),
        .blackjack_o  (blackjack_o),
        .busy_o       (busy_o),
`ifdef BLACKJACK_DEALER_AUTO_EN
        .stand_o      (stand_o),
`endif
        .err_o        (err_o)
    );

    always #5 clk_dp_i = ~clk_dp_i;

    always @(negedge clk_dp_i) if (req_card_o === 1'b1) reqCount++;

    task automatic newHand();
        new_hand_i = 1'b1;
        @(negedge clk_dp_i);
        new_hand_i = 1'b0;
    endtask

    // Hit, then play the deck path: card_valid_i during the cycle after the request strobe.
    task automatic applyStimulus(input logic [7:0] code);
        int n;
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        n = 0;
        while (req_card_o !== 1'b1 && n < 8) begin @(negedge clk_dp_i); n++; end
        checks++;
        if (req_card_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL deal_req: req_card_o=%b expected 1", req_card_o);
        end else begin
            @(negedge clk_dp_i);
            card_i = code;
            card_valid_i = 1'b1;
            @(negedge clk_dp_i);
            card_valid_i = 1'b0;
            card_i = 8'h00;
            n = 0;
            while (busy_o !== 1'b0 && n < 8) begin @(negedge clk_dp_i); n++; end
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL deal_idle: busy_o=%b expected 0", busy_o);
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (score_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d expected 0", score_o); end
        checks++; if (card_count_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", card_count_o); end
        checks++; if ({soft_o, bust_o, blackjack_o, busy_o, err_o, req_card_o} !== 6'b0)
            begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {soft_o, bust_o, blackjack_o, busy_o, err_o, req_card_o}); end
    endtask

`ifdef BLACKJACK_DEALER_AUTO_EN
    task automatic test_dealer_auto();
        logic [7:0] codes [2] = '{8'h01, 8'h06};
        int n, startReq;
        newHand();
        startReq = reqCount;
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (req_card_o !== 1'b1 && n < 8) begin @(negedge clk_dp_i); n++; end
            @(negedge clk_dp_i);
            card_i = codes[i];
            card_valid_i = 1'b1;
            @(negedge clk_dp_i);
            card_valid_i = 1'b0;
        end
        repeat (6) @(negedge clk_dp_i);
        checks++; if (reqCount - startReq != 2) begin errors++; $display("[TB] FAIL auto_requests: got %0d expected 2", reqCount - startReq); end
        checks++; if (score_o !== 5'd17) begin errors++; $display("[TB] FAIL auto_score: got %0d expected 17", score_o); end
        checks++; if (soft_o !== 1'b1) begin errors++; $display("[TB] FAIL auto_soft: got %b expected 1", soft_o); end
        checks++; if (stand_o !== 1'b1) begin errors++; $display("[TB] FAIL auto_stand: got %b expected 1", stand_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL auto_busy: got %b expected 0", busy_o); end
        newHand();
        checks++; if (stand_o !== 1'b0) begin errors++; $display("[TB] FAIL auto_stand_clear: got %b expected 0", stand_o); end
    endtask
`else
    task automatic test_blackjack();
        int startReq;
        newHand();
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        @(negedge clk_dp_i);
        card_i = 8'h01;
        card_valid_i = 1'b1;
        @(negedge clk_dp_i);
        card_valid_i = 1'b0;
        checks++; if (score_o !== 5'd0) begin errors++; $display("[TB] FAIL latency_early: got %0d expected 0", score_o); end
        @(negedge clk_dp_i);
        checks++; if (score_o !== 5'd11) begin errors++; $display("[TB] FAIL latency_4: got %0d expected 11", score_o); end
        applyStimulus(8'h0D);
        checks++; if (score_o !== 5'd21) begin errors++; $display("[TB] FAIL bj_score: got %0d expected 21", score_o); end
        checks++; if (soft_o !== 1'b1) begin errors++; $display("[TB] FAIL bj_soft: got %b expected 1", soft_o); end
        checks++; if (blackjack_o !== 1'b1) begin errors++; $display("[TB] FAIL bj_flag: got %b expected 1", blackjack_o); end
        checks++; if (card_count_o !== 4'd2) begin errors++; $display("[TB] FAIL bj_count: got %0d expected 2", card_count_o); end
        startReq = reqCount;
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        repeat (4) @(negedge clk_dp_i);
        checks++; if (reqCount != startReq) begin errors++; $display("[TB] FAIL hit_at_21: requests %0d expected 0", reqCount - startReq); end
    endtask

    task automatic test_soft_aces();
        newHand();
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        checks++; if (score_o !== 5'd12) begin errors++; $display("[TB] FAIL aces_score2: got %0d expected 12", score_o); end
        checks++; if (soft_o !== 1'b1) begin errors++; $display("[TB] FAIL aces_soft2: got %b expected 1", soft_o); end
        applyStimulus(8'h19);
        checks++; if (score_o !== 5'd21) begin errors++; $display("[TB] FAIL aces_score3: got %0d expected 21", score_o); end
        checks++; if ({soft_o, blackjack_o} !== 2'b10) begin errors++; $display("[TB] FAIL aces_flags3: got %b expected 10", {soft_o, blackjack_o}); end
        checks++; if (card_count_o !== 4'd3) begin errors++; $display("[TB] FAIL aces_count3: got %0d expected 3", card_count_o); end
    endtask

    task automatic test_bust();
        int startReq;
        newHand();
        applyStimulus(8'h0A);
        applyStimulus(8'h06);
        applyStimulus(8'h2C);
        checks++; if (score_o !== 5'd26) begin errors++; $display("[TB] FAIL bust_score: got %0d expected 26", score_o); end
        checks++; if ({bust_o, soft_o} !== 2'b10) begin errors++; $display("[TB] FAIL bust_flags: got %b expected 10", {bust_o, soft_o}); end
        startReq = reqCount;
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        repeat (4) @(negedge clk_dp_i);
        checks++; if (reqCount != startReq) begin errors++; $display("[TB] FAIL bust_hit: requests %0d expected 0", reqCount - startReq); end
    endtask

    task automatic test_max_cards();
        int startReq;
        newHand();
        for (int i = 0; i < 10; i++) applyStimulus(8'h01);
        checks++; if (score_o !== 5'd20) begin errors++; $display("[TB] FAIL max_score10: got %0d expected 20", score_o); end
        applyStimulus(8'h02);
        checks++; if (score_o !== 5'd12 || card_count_o !== 4'd11 || soft_o !== 1'b0)
            begin errors++; $display("[TB] FAIL max_hand11: score %0d count %0d soft %b expected 12 11 0", score_o, card_count_o, soft_o); end
        startReq = reqCount;
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        repeat (4) @(negedge clk_dp_i);
        checks++; if (reqCount != startReq) begin errors++; $display("[TB] FAIL max_hit: requests %0d expected 0", reqCount - startReq); end
    endtask

    task automatic test_timeout();
        newHand();
        applyStimulus(8'h05);
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        repeat (15) @(negedge clk_dp_i);
        checks++; if ({busy_o, err_o} !== 2'b10) begin errors++; $display("[TB] FAIL timeout_early: busy/err %b expected 10", {busy_o, err_o}); end
        @(negedge clk_dp_i);
        checks++; if ({busy_o, err_o} !== 2'b01) begin errors++; $display("[TB] FAIL timeout_abort: busy/err %b expected 01", {busy_o, err_o}); end
        checks++; if (score_o !== 5'd5 || card_count_o !== 4'd1)
            begin errors++; $display("[TB] FAIL timeout_hand: score %0d count %0d expected 5 1", score_o, card_count_o); end
        newHand();
        checks++; if (err_o !== 1'b0 || score_o !== 5'd0) begin errors++; $display("[TB] FAIL timeout_clear: err %b score %0d expected 0 0", err_o, score_o); end
    endtask

    task automatic test_invalid_and_abort();
        int startReq;
        newHand();
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL inv0_err: got %b expected 1", err_o); end
        checks++; if (card_count_o !== 4'd1 || score_o !== 5'd4)
            begin errors++; $display("[TB] FAIL inv0_hand: count %0d score %0d expected 1 4", card_count_o, score_o); end
        newHand();
        applyStimulus(8'h0E);
        checks++; if (err_o !== 1'b1 || card_count_o !== 4'd0)
            begin errors++; $display("[TB] FAIL inv14: err %b count %0d expected 1 0", err_o, card_count_o); end
        newHand();
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        hit_i = 1'b0;
        @(negedge clk_dp_i);
        new_hand_i = 1'b1;
        @(negedge clk_dp_i);
        new_hand_i = 1'b0;
        card_i = 8'h0A;
        card_valid_i = 1'b1;
        @(negedge clk_dp_i);
        card_valid_i = 1'b0;
        card_i = 8'h00;
        repeat (2) @(negedge clk_dp_i);
        checks++; if ({score_o, card_count_o, soft_o, bust_o, blackjack_o, busy_o, err_o} !== 14'd0)
            begin errors++; $display("[TB] FAIL abort_wait: score %0d count %0d busy %b err %b expected all 0", score_o, card_count_o, busy_o, err_o); end
        startReq = reqCount;
        new_hand_i = 1'b1;
        hit_i = 1'b1;
        @(negedge clk_dp_i);
        new_hand_i = 1'b0;
        hit_i = 1'b0;
        repeat (3) @(negedge clk_dp_i);
        checks++; if (reqCount != startReq || busy_o !== 1'b0)
            begin errors++; $display("[TB] FAIL newhand_hit: requests %0d busy %b expected 0 0", reqCount - startReq, busy_o); end
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk_dp_i);
        rst_dp_i = 1'b1;
        @(negedge clk_dp_i);
        test_reset();
`ifdef BLACKJACK_DEALER_AUTO_EN
        test_dealer_auto();
`else
        test_blackjack();
        test_soft_aces();
        test_bust();
        test_max_cards();
        test_timeout();
        test_invalid_and_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
